pwm_multi: RTL

Multi-channel PWM generator; the parametrised successor to the single-channel PWM used for motor and servo drive. All `CH` channels share one prescaler and one period counter. Each channel has a double-buffered duty register (shadow → active at the period boundary) and per-channel output polarity, with an optional center-aligned mode. It sits between the register/command interface and the motor-driver pins.

---
 rtl/pwm_pkg.sv | 24 ++
 rtl/pwm_prescaler.sv | 37 +++
 rtl/pwm_multi.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// Shared types and width helpers for the multi-channel PWM block.
package pwm_pkg;

  typedef enum logic {
    PWM_EDGE,
    PWM_CENTER
  } pwm_mode_e;

  // Width of the period counter for a given modulus.
  function automatic int unsigned pwm_cnt_w(input int unsigned top);
    return $clog2(top);
  endfunction

  // Duty width: one extra bit so that a value >= TOP (100 %) is expressible.
  function automatic int unsigned pwm_duty_w(input int unsigned top);
    return $clog2(top) + 1;
  endfunction

  // $clog2 clamped to at least one bit, for selects over a count of n items.
  function automatic int unsigned pwm_min1_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Tick generator: pulses tick_o once every PREDIV clocks; clr_i holds it at phase 0.
module pwm_prescaler
  import pwm_pkg::*;
#(
  parameter int unsigned PREDIV = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned W = pwm_min1_w(PREDIV);
  localparam logic [W-1:0] Last = W'(PREDIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign tick_o = !clr_i && (cnt_q == Last);

  // Wrap at PREDIV-1; a clear restarts the phase so the first tick is PREDIV clocks away.
  always_comb begin
    cnt_d = cnt_q + W'(1);
    if (clr_i || (cnt_q == Last)) begin
      cnt_d = '0;
    end
  end

  // Phase register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM: shared prescaler and period counter, double-buffered per-channel
// duty, per-channel polarity. Define PWM_CENTER_ALIGN_EN to enable center-aligned mode.
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int unsigned   CH     = 4,
  parameter int unsigned   TOP    = 1024,
  parameter int unsigned   PREDIV = 2,
  parameter logic [CH-1:0] POL    = '0
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        enable_i,
  input  logic                        center_i,
  input  logic                        wr_en_i,
  input  logic [pwm_min1_w(CH)-1:0]   wr_ch_i,
  input  logic [pwm_duty_w(TOP)-1:0]  wr_duty_i,
  output logic [CH-1:0]               out_o,
  output logic                        period_start_o
);

  localparam int unsigned CW = pwm_cnt_w(TOP);
  localparam int unsigned DW = pwm_duty_w(TOP);
  localparam logic [CW-1:0] CntMax = CW'(TOP - 1);

  logic          tick;
  logic          boundary;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] shadow_q [CH];
  logic [DW-1:0] shadow_d [CH];
  logic [DW-1:0] active_q [CH];
  logic [DW-1:0] active_d [CH];
  logic          bnd_q, ps_q;
  logic [CH-1:0] raw, out_q, out_d;

  pwm_prescaler #(
    .PREDIV(PREDIV)
  ) u_prescaler (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (!enable_i),
    .tick_o(tick)
  );

`ifdef PWM_CENTER_ALIGN_EN
  logic      dir_q, dir_d;  // 1 = counting down
  pwm_mode_e mode_q, mode_d;

  // Direction and latched mode.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dir_q  <= 1'b0;
      mode_q <= PWM_EDGE;
    end else begin
      dir_q  <= dir_d;
      mode_q <= mode_d;
    end
  end
`else
  logic unused_center;
  assign unused_center = center_i;
`endif

  // Period counter next state and boundary detection.
  always_comb begin
    cnt_d    = cnt_q;
    boundary = 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
    dir_d    = dir_q;
    mode_d   = mode_q;
`endif
    if (!enable_i) begin
      cnt_d = '0;
`ifdef PWM_CENTER_ALIGN_EN
      dir_d  = 1'b0;
      mode_d = center_i ? PWM_CENTER : PWM_EDGE;
`endif
    end else if (tick) begin
`ifdef PWM_CENTER_ALIGN_EN
      // Endpoints hold for two ticks: the turn-around tick only flips direction.
      if (mode_q == PWM_CENTER) begin
        if (!dir_q) begin
          if (cnt_q == CntMax) begin
            dir_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else if (cnt_q == '0) begin
          dir_d    = 1'b0;
          boundary = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end else
`endif
      begin
        if (cnt_q == CntMax) begin
          cnt_d    = '0;
          boundary = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`ifdef PWM_CENTER_ALIGN_EN
      if (boundary) begin
        mode_d = center_i ? PWM_CENTER : PWM_EDGE;
      end
`endif
    end
  end

  // Duty buffers: a boundary takes the pre-write shadow; while stopped, track writes directly.
  always_comb begin
    shadow_d = shadow_q;
    if (wr_en_i && (32'(wr_ch_i) < CH)) begin
      shadow_d[wr_ch_i] = wr_duty_i;
    end
    active_d = active_q;
    if (!enable_i) begin
      active_d = shadow_d;
    end else if (boundary) begin
      active_d = shadow_q;
    end
  end

  for (genvar i = 0; i < CH; i++) begin : g_ch
    assign raw[i] = ({1'b0, cnt_q} < active_q[i]);
  end

  assign out_d          = enable_i ? (raw ^ POL) : POL;
  assign out_o          = out_q;
  assign period_start_o = ps_q;

  // Counter, duty buffers and registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      bnd_q <= 1'b0;
      ps_q  <= 1'b0;
      out_q <= POL;
      for (int i = 0; i < CH; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      cnt_q    <= cnt_d;
      bnd_q    <= boundary;
      // Delayed one clock so the pulse lines up with the first output of the new period.
      ps_q     <= enable_i & bnd_q;
      out_q    <= out_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

endmodule
